// File: rtl/rvx10_pkg.sv
// Shared fetch-stage constants and the fetch FSM state type.
package rvx10_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DISCARD
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: a bubble beats a load, and with neither the contents hold.
module ifid_reg #(
  parameter logic [31:0] NOP_INSTR = rvx10_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else if (bubble_i) begin
      // The PC fields are kept so ID still sees the last real PC.
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_plus4_i;
      valid_q    <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one-outstanding-request FSM, PCF, a one-entry hold buffer
// for words that return while ID is stalled, and the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = rvx10_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = rvx10_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  import rvx10_pkg::*;

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic         hold_valid_q;
  logic [31:0]  hold_instr_q;
  logic [31:0]  hold_pc_q;

  logic [31:0]  pc_plus4;
  logic         wait_hit;
  logic         hold_hit;
  logic         ifid_load;
  logic         ifid_bubble;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc;

  assign pc_plus4 = pc_q + 32'd4;

  // A response in WAIT consumed by ID lets the next request go out in the same cycle.
  assign wait_hit  = (state_q == WAIT) && imem_valid;
  assign hold_hit  = (state_q == HOLD) && hold_valid_q;
  assign imem_req  = (state_q == REQ) || (wait_hit && !StallD && !PCSrcE);
  assign imem_addr = (state_q == WAIT) ? pc_plus4 : pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      hold_valid_q <= 1'b0;
    end else if (PCSrcE) begin
      pc_q         <= PCTargetE;
      hold_valid_q <= 1'b0;
      unique case (state_q)
        IDLE:    state_q <= REQ;
        REQ:     state_q <= DISCARD;
        WAIT:    state_q <= imem_valid ? REQ : DISCARD;
        HOLD:    state_q <= REQ;
        DISCARD: state_q <= imem_valid ? REQ : DISCARD;
        default: state_q <= IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE:    state_q <= REQ;
        REQ:     state_q <= WAIT;
        WAIT: begin
          if (imem_valid && StallD) begin
            hold_valid_q <= 1'b1;
            state_q      <= HOLD;
          end else if (imem_valid) begin
            pc_q <= pc_plus4;
          end
        end
        HOLD: begin
          if (!StallD) begin
            hold_valid_q <= 1'b0;
            pc_q         <= pc_plus4;
            state_q      <= REQ;
          end
        end
        DISCARD: if (imem_valid) state_q <= REQ;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the hold payload is qualified by hold_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wait_hit && StallD && !PCSrcE) begin
      hold_instr_q <= imem_rdata;
      hold_pc_q    <= pc_q;
    end
  end

  // PCSrcE and FlushD both squash IF/ID, even over a stall.
  assign ifid_load   = !StallD && (wait_hit || hold_hit);
  assign ifid_bubble = PCSrcE || FlushD || (!StallD && !(wait_hit || hold_hit));
  assign ifid_instr  = hold_hit ? hold_instr_q : imem_rdata;
  assign ifid_pc     = hold_hit ? hold_pc_q : pc_q;

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk       (clk),
    .reset     (reset),
    .load_i    (ifid_load),
    .bubble_i  (ifid_bubble),
    .instr_i   (ifid_instr),
    .pc_i      (ifid_pc),
    .pc_plus4_i(ifid_pc + 32'd4),
    .instr_o   (InstrD),
    .pc_o      (PCD),
    .pc_plus4_o(PCPlus4D),
    .valid_o   (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the testbench plays the instruction memory
// cycle by cycle and checks every output against hand-computed values.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_valid(imem_valid),
    .imem_rdata(imem_rdata),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are checked 1 ns later.
  task automatic cyc(input logic v, input logic [31:0] rd, input logic st,
                     input logic fl, input logic ps, input logic [31:0] tg);
    @(negedge clk);
    imem_valid = v;
    imem_rdata = rd;
    StallD     = st;
    FlushD     = fl;
    PCSrcE     = ps;
    PCTargetE  = tg;
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc, input logic valid);
    check({tag, ".InstrD"}, InstrD, instr);
    check({tag, ".PCD"}, PCD, pc);
    check({tag, ".ValidD"}, {31'b0, ValidD}, {31'b0, valid});
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, req});
    if (req) check({tag, ".imem_addr"}, imem_addr, addr);
  endtask

  initial begin
    reset      = 1'b1;
    StallD     = 1'b0;
    FlushD     = 1'b0;
    PCSrcE     = 1'b0;
    PCTargetE  = 32'h0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    repeat (2) @(posedge clk);

    // Reset values, then release: IDLE for one cycle
    cyc(0, 32'h0, 0, 0, 0, 32'h0);
    check_ifid("rst", NOP, 32'h0, 1'b0);
    check("rst.PCPlus4D", PCPlus4D, 32'h0);
    check_req("rst", 1'b0, 32'h0);
    reset = 1'b0;

    // Back-to-back fetch with a 1-cycle memory
    cyc(0, 32'h0, 0, 0, 0, 32'h0);
    check_req("req0", 1'b1, 32'h0000_0000);
    cyc(1, 32'h0050_0093, 0, 0, 0, 32'h0);
    check_req("b2b4", 1'b1, 32'h0000_0004);
    check("b2b4.ValidD", {31'b0, ValidD}, 32'h0);
    cyc(1, 32'h00A0_0113, 0, 0, 0, 32'h0);
    check_ifid("i0", 32'h0050_0093, 32'h0, 1'b1);
    check("i0.PCPlus4D", PCPlus4D, 32'h4);
    check_req("b2b8", 1'b1, 32'h0000_0008);

    // Stall for two cycles as the 0x8 word returns
    cyc(1, 32'h00C0_0193, 1, 0, 0, 32'h0);
    check_ifid("i4", 32'h00A0_0113, 32'h4, 1'b1);
    check_req("stall1", 1'b0, 32'h0);
    cyc(0, 32'h0, 1, 0, 0, 32'h0);
    check_ifid("hold", 32'h00A0_0113, 32'h4, 1'b1);
    check_req("stall2", 1'b0, 32'h0);
    cyc(0, 32'h0, 0, 0, 0, 32'h0);
    check_req("release", 1'b0, 32'h0);
    cyc(0, 32'h0, 0, 0, 0, 32'h0);
    check_ifid("i8", 32'h00C0_0193, 32'h8, 1'b1);
    check("i8.PCPlus4D", PCPlus4D, 32'hC);
    check_req("reqC", 1'b1, 32'h0000_000C);
    cyc(1, 32'h0010_0213, 0, 0, 0, 32'h0);
    check_ifid("bubC", NOP, 32'h8, 1'b0);
    check_req("b2b10", 1'b1, 32'h0000_0010);

    // Redirect to 0x40 while the 0x10 request is outstanding
    cyc(0, 32'h0, 0, 0, 1, 32'h0000_0040);
    check_ifid("iC", 32'h0010_0213, 32'hC, 1'b1);
    check_req("redir", 1'b0, 32'h0);
    cyc(1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0);
    check_ifid("disc", NOP, 32'hC, 1'b0);
    check_req("disc", 1'b0, 32'h0);
    cyc(0, 32'h0, 0, 0, 0, 32'h0);
    check_ifid("stale", NOP, 32'hC, 1'b0);
    check_req("req40", 1'b1, 32'h0000_0040);
    cyc(1, 32'h0070_0393, 0, 0, 0, 32'h0);
    check("w40.ValidD", {31'b0, ValidD}, 32'h0);
    check_req("b2b44", 1'b1, 32'h0000_0044);

    // Redirect coincident with a response while ID stalls
    cyc(1, 32'h1234_5678, 1, 0, 1, 32'h0000_0080);
    check_ifid("i40", 32'h0070_0393, 32'h40, 1'b1);
    check_req("redir2", 1'b0, 32'h0);
    cyc(0, 32'h0, 0, 0, 0, 32'h0);
    check_ifid("drop", NOP, 32'h40, 1'b0);
    check_req("req80", 1'b1, 32'h0000_0080);

    // Reset while in WAIT, with a late response after it
    cyc(0, 32'h0, 0, 0, 0, 32'h0);
    reset = 1'b1;
    cyc(1, 32'hBAD0_BAD0, 0, 0, 0, 32'h0);
    check_ifid("rst2", NOP, 32'h0, 1'b0);
    check("rst2.PCPlus4D", PCPlus4D, 32'h0);
    check_req("rst2", 1'b0, 32'h0);
    reset = 1'b0;
    cyc(1, 32'hBAD0_BAD0, 0, 0, 0, 32'h0);
    check_ifid("late", NOP, 32'h0, 1'b0);
    check_req("restart", 1'b1, 32'h0000_0000);

    // Redirect to the top of the address space
    cyc(0, 32'h0, 0, 0, 1, 32'hFFFF_FFFC);
    check_ifid("ign", NOP, 32'h0, 1'b0);
    check_req("redir3", 1'b0, 32'h0);
    cyc(1, 32'h0050_0093, 0, 0, 0, 32'h0);
    check_req("disc2", 1'b0, 32'h0);
    cyc(0, 32'h0, 0, 0, 0, 32'h0);
    check_req("reqTop", 1'b1, 32'hFFFF_FFFC);
    cyc(1, 32'h0FF0_0513, 0, 0, 0, 32'h0);
    check_req("wrap", 1'b1, 32'h0000_0000);

    // FlushD squashes the incoming word but the fetch still advances
    cyc(1, 32'h0050_0093, 0, 1, 0, 32'h0);
    check_ifid("iTop", 32'h0FF0_0513, 32'hFFFF_FFFC, 1'b1);
    check("iTop.PCPlus4D", PCPlus4D, 32'h0000_0000);
    check_req("flushReq", 1'b1, 32'h0000_0004);
    cyc(0, 32'h0, 0, 0, 0, 32'h0);
    check_ifid("flush", NOP, 32'hFFFF_FFFC, 1'b0);
    check_req("flushWait", 1'b0, 32'h0);
    cyc(1, 32'h00A0_0113, 0, 0, 0, 32'h0);
    check_req("after", 1'b1, 32'h0000_0008);
    cyc(0, 32'h0, 0, 0, 0, 32'h0);
    check_ifid("i4b", 32'h00A0_0113, 32'h4, 1'b1);
    check("i4b.PCPlus4D", PCPlus4D, 32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
